sphere3hopf_seq_driver: RTL

- Initiator/collector for the sphere3hopf FSM generator: drives its start/k_in/base_sel request side and consumes its result/done/ready side.
- Issues a run of consecutive indices k, captures each 4-D Q16.16 point and checks that x²+y²+z²+w² ≈ 1.0.
- Emits each point on a valid/ready stream toward downstream consumers.
- Replaces the bench-style "wait ready, pulse start, wait done" sequence with synthesizable logic.

---
 rtl/sphere3hopf_seq_driver_if.sv | 40 ++++
 rtl/sphere3hopf_seq_driver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sphere3hopf_seq_driver_if.sv
// Generator request/result handshake plus the outgoing point stream.
// master = sequencer side, slave = generator + downstream consumer side.
interface sphere3hopf_seq_driver_if #(
    parameter int K_W = 32
);
    logic           gen_start;
    logic [K_W-1:0] gen_k;
    logic [1:0]     gen_base_sel0;
    logic [1:0]     gen_base_sel1;
    logic [1:0]     gen_base_sel2;
    logic [31:0]    gen_result_x;
    logic [31:0]    gen_result_y;
    logic [31:0]    gen_result_z;
    logic [31:0]    gen_result_w;
    logic           gen_done;
    logic           gen_ready;

    logic           pt_valid;
    logic           pt_ready;
    logic [K_W-1:0] pt_k;
    logic [31:0]    pt_x;
    logic [31:0]    pt_y;
    logic [31:0]    pt_z;
    logic [31:0]    pt_w;
    logic           pt_norm_ok;

    modport master (
        output gen_start, gen_k, gen_base_sel0, gen_base_sel1, gen_base_sel2,
        input  gen_result_x, gen_result_y, gen_result_z, gen_result_w, gen_done, gen_ready,
        output pt_valid, pt_k, pt_x, pt_y, pt_z, pt_w, pt_norm_ok,
        input  pt_ready
    );

    modport slave (
        input  gen_start, gen_k, gen_base_sel0, gen_base_sel1, gen_base_sel2,
        output gen_result_x, gen_result_y, gen_result_z, gen_result_w, gen_done, gen_ready,
        input  pt_valid, pt_k, pt_x, pt_y, pt_z, pt_w, pt_norm_ok,
        output pt_ready
    );
endinterface

// File: rtl/sphere3hopf_seq_driver.sv
// Sequences a run of k indices through the sphere3hopf generator, checks each
// point's unit norm and forwards it on a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for cfg_start
// ISSUE | waiting for gen_ready, then pulse gen_start
// WAIT  | waiting for gen_done or timeout
// NORM  | four multiply-accumulate steps forming x^2+y^2+z^2+w^2
// EMIT  | presenting the point until pt_ready
// FIN   | one-cycle run_done, back to IDLE
module sphere3hopf_seq_driver #(
    parameter int          K_W      = 32,
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NORM_TOL = 32'h0000_0200,
    parameter int          TIMEOUT  = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [K_W-1:0]   cfg_k_first,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [1:0]       cfg_base_sel0,
    input  logic [1:0]       cfg_base_sel1,
    input  logic [1:0]       cfg_base_sel2,
    output logic             busy,
    output logic             run_done,
    output logic             err_timeout,
    output logic [CNT_W-1:0] err_norm_cnt,
    sphere3hopf_seq_driver_if.master bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NORM, EMIT, FIN} state_t;

    localparam int          TMO_W   = $clog2(TIMEOUT + 1);
    localparam logic [35:0] ONE_Q16 = 36'h0_0001_0000;

    state_t           state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [1:0]       bsel0_q, bsel0_d, bsel1_q, bsel1_d, bsel2_q, bsel2_d;
    logic             busy_q, busy_d, run_done_q, run_done_d, gen_start_q, gen_start_d;
    logic             pt_valid_q, pt_valid_d, pt_norm_ok_q, pt_norm_ok_d;
    logic [K_W-1:0]   pt_k_q, pt_k_d;
    logic [31:0]      pt_x_q, pt_x_d, pt_y_q, pt_y_d, pt_z_q, pt_z_d, pt_w_q, pt_w_d;
    logic             err_timeout_q, err_timeout_d;
    logic [CNT_W-1:0] err_norm_cnt_q, err_norm_cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [1:0]       step_q, step_d;
    logic [35:0]      sum_q, sum_d;

    logic signed [31:0] mul_a;
    logic signed [63:0] prod;
    logic [35:0]        sum_next;
    logic [35:0]        norm_diff;
    logic               norm_ok_now;

    // One shared multiplier; step_q picks the component squared this cycle.
    always_comb begin
        case (step_q)
            2'd0:    mul_a = pt_x_q;
            2'd1:    mul_a = pt_y_q;
            2'd2:    mul_a = pt_z_q;
            default: mul_a = pt_w_q;
        endcase
        prod        = 64'(mul_a) * 64'(mul_a);
        sum_next    = sum_q + 36'(prod >>> 16);
        norm_diff   = (sum_next >= ONE_Q16) ? (sum_next - ONE_Q16) : (ONE_Q16 - sum_next);
        norm_ok_now = (norm_diff <= 36'(NORM_TOL));
    end

    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        remain_d       = remain_q;
        bsel0_d        = bsel0_q;
        bsel1_d        = bsel1_q;
        bsel2_d        = bsel2_q;
        busy_d         = busy_q;
        run_done_d     = 1'b0;
        gen_start_d    = 1'b0;
        pt_valid_d     = pt_valid_q;
        pt_norm_ok_d   = pt_norm_ok_q;
        pt_k_d         = pt_k_q;
        pt_x_d         = pt_x_q;
        pt_y_d         = pt_y_q;
        pt_z_d         = pt_z_q;
        pt_w_d         = pt_w_q;
        err_timeout_d  = err_timeout_q;
        err_norm_cnt_d = err_norm_cnt_q;
        tmo_d          = tmo_q;
        step_d         = step_q;
        sum_d          = sum_q;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    k_d            = cfg_k_first;
                    remain_d       = cfg_count;
                    bsel0_d        = cfg_base_sel0;
                    bsel1_d        = cfg_base_sel1;
                    bsel2_d        = cfg_base_sel2;
                    busy_d         = 1'b1;
                    err_timeout_d  = 1'b0;
                    err_norm_cnt_d = '0;
                    state_d        = (cfg_count == '0) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                if (bus.gen_ready) begin
                    gen_start_d = 1'b1;
                    tmo_d       = TMO_W'(TIMEOUT - 1);
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                // gen_done alongside our own start pulse belongs to a stale request.
                if (bus.gen_done && !gen_start_q) begin
                    pt_k_d  = k_q;
                    pt_x_d  = bus.gen_result_x;
                    pt_y_d  = bus.gen_result_y;
                    pt_z_d  = bus.gen_result_z;
                    pt_w_d  = bus.gen_result_w;
                    sum_d   = '0;
                    step_d  = '0;
                    state_d = NORM;
                end else if (tmo_q == '0) begin
                    err_timeout_d = 1'b1;
                    state_d       = FIN;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            NORM: begin
                sum_d  = sum_next;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    pt_norm_ok_d = norm_ok_now;
                    if (!norm_ok_now && !(&err_norm_cnt_q))
                        err_norm_cnt_d = err_norm_cnt_q + CNT_W'(1);
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (pt_valid_q && bus.pt_ready) begin
                    pt_valid_d = 1'b0;
                    remain_d   = remain_q - CNT_W'(1);
                    k_d        = k_q + K_W'(1);
                    state_d    = (remain_q == CNT_W'(1)) ? FIN : ISSUE;
                end else begin
                    pt_valid_d = 1'b1;
                end
            end
            FIN: begin
                run_done_d = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            k_q            <= '0;
            remain_q       <= '0;
            bsel0_q        <= '0;
            bsel1_q        <= '0;
            bsel2_q        <= '0;
            busy_q         <= 1'b0;
            run_done_q     <= 1'b0;
            gen_start_q    <= 1'b0;
            pt_valid_q     <= 1'b0;
            pt_norm_ok_q   <= 1'b0;
            pt_k_q         <= '0;
            pt_x_q         <= '0;
            pt_y_q         <= '0;
            pt_z_q         <= '0;
            pt_w_q         <= '0;
            err_timeout_q  <= 1'b0;
            err_norm_cnt_q <= '0;
            tmo_q          <= '0;
            step_q         <= '0;
            sum_q          <= '0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            remain_q       <= remain_d;
            bsel0_q        <= bsel0_d;
            bsel1_q        <= bsel1_d;
            bsel2_q        <= bsel2_d;
            busy_q         <= busy_d;
            run_done_q     <= run_done_d;
            gen_start_q    <= gen_start_d;
            pt_valid_q     <= pt_valid_d;
            pt_norm_ok_q   <= pt_norm_ok_d;
            pt_k_q         <= pt_k_d;
            pt_x_q         <= pt_x_d;
            pt_y_q         <= pt_y_d;
            pt_z_q         <= pt_z_d;
            pt_w_q         <= pt_w_d;
            err_timeout_q  <= err_timeout_d;
            err_norm_cnt_q <= err_norm_cnt_d;
            tmo_q          <= tmo_d;
            step_q         <= step_d;
            sum_q          <= sum_d;
        end
    end

    assign busy              = busy_q;
    assign run_done          = run_done_q;
    assign err_timeout       = err_timeout_q;
    assign err_norm_cnt      = err_norm_cnt_q;
    assign bus.gen_start     = gen_start_q;
    assign bus.gen_k         = k_q;
    assign bus.gen_base_sel0 = bsel0_q;
    assign bus.gen_base_sel1 = bsel1_q;
    assign bus.gen_base_sel2 = bsel2_q;
    assign bus.pt_valid      = pt_valid_q;
    assign bus.pt_k          = pt_k_q;
    assign bus.pt_x          = pt_x_q;
    assign bus.pt_y          = pt_y_q;
    assign bus.pt_z          = pt_z_q;
    assign bus.pt_w          = pt_w_q;
    assign bus.pt_norm_ok    = pt_norm_ok_q;
endmodule
